// File: rtl/chess_clock.sv
// Multi-player chess clock: per-player mm:ss countdown with Fischer increment, pause and flag detection.
// The BCD display of the active player's time is registered and trails the stored time by one cycle.
module chess_clock #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int NUM_PLAYERS = 2,
  parameter int PW          = $clog2(NUM_PLAYERS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [1:0]    mode_sel,
  input  logic          start,
  input  logic          pause,
  input  logic          moved,
  output logic [PW-1:0] active_player,
  output logic [15:0]   disp_bcd,
  output logic [2:0]    state,
  output logic          time_up,
  output logic [PW-1:0] flagged_player,
  output logic          low_time
);
  localparam int            CW          = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [CW-1:0] PRESC_MAX   = CW'(CLK_FREQ_HZ - 1);
  localparam logic [PW-1:0] LAST_PLAYER = PW'(NUM_PLAYERS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READY   = 3'd1,
    S_RUNNING = 3'd2,
    S_PAUSED  = 3'd3,
    S_FLAGGED = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [6:0]    r_min [NUM_PLAYERS];
  logic [5:0]    r_sec [NUM_PLAYERS];
  logic [CW-1:0] r_presc;
  logic [PW-1:0] r_active, r_flagged;
  logic [1:0]    r_mode;
  logic [15:0]   r_disp;

  logic          w_running, w_tick, w_flag, w_move;
  logic [6:0]    w_cur_min, w_dec_min, w_inc_min, w_base_min, w_sec_sum;
  logic [5:0]    w_cur_sec, w_dec_sec, w_inc_sec;
  logic [2:0]    w_inc;

  function automatic logic [15:0] to_bcd(input logic [6:0] m, input logic [5:0] s);
    return {4'(m / 7'd10), 4'(m % 7'd10), 4'(s / 6'd10), 4'(s % 6'd10)};
  endfunction

  // Base minutes come from the live selector at load; the increment is latched with it.
  always_comb begin
    w_base_min = 7'd1;
    case (mode_sel)
      2'd0:    w_base_min = 7'd1;
      2'd1:    w_base_min = 7'd3;
      2'd2:    w_base_min = 7'd5;
      default: w_base_min = 7'd10;
    endcase
  end

  always_comb begin
    w_inc = 3'd0;
    case (r_mode)
      2'd1:    w_inc = 3'd2;
      2'd3:    w_inc = 3'd5;
      default: w_inc = 3'd0;
    endcase
  end

  assign w_running = (r_state == S_RUNNING);
  assign w_tick    = w_running && (r_presc == PRESC_MAX);
  assign w_cur_min = r_min[r_active];
  assign w_cur_sec = r_sec[r_active];

  always_comb begin
    w_dec_min = w_cur_min;
    w_dec_sec = w_cur_sec;
    if (w_tick) begin
      if (w_cur_sec == 6'd0) begin
        w_dec_min = w_cur_min - 7'd1;
        w_dec_sec = 6'd59;
      end else begin
        w_dec_sec = w_cur_sec - 6'd1;
      end
    end
  end

  // Reaching 00:00 on a tick beats a simultaneous move.
  assign w_flag    = w_tick && (w_dec_min == 7'd0) && (w_dec_sec == 6'd0);
  assign w_move    = w_running && moved && !w_flag;
  assign w_sec_sum = {1'b0, w_dec_sec} + {4'd0, w_inc};

  always_comb begin
    w_inc_min = w_dec_min;
    w_inc_sec = w_sec_sum[5:0];
    if (w_sec_sum >= 7'd60) begin
      if (w_dec_min >= 7'd99) begin
        w_inc_min = 7'd99;
        w_inc_sec = 6'd59;
      end else begin
        w_inc_min = w_dec_min + 7'd1;
        w_inc_sec = 6'(w_sec_sum - 7'd60);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (load) begin
      w_state_nxt = S_READY;
    end else begin
      case (r_state)
        S_READY, S_PAUSED: if (start) w_state_nxt = S_RUNNING;
        S_RUNNING: begin
          if (w_flag)     w_state_nxt = S_FLAGGED;
          else if (pause) w_state_nxt = S_PAUSED;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        r_min[i] <= '0;
        r_sec[i] <= '0;
      end
      r_presc   <= '0;
      r_active  <= '0;
      r_flagged <= '0;
      r_mode    <= '0;
      r_disp    <= '0;
    end else begin
      r_disp <= (r_state == S_IDLE) ? 16'h0000 : to_bcd(w_cur_min, w_cur_sec);
      if (load) begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          r_min[i] <= w_base_min;
          r_sec[i] <= '0;
        end
        r_presc   <= '0;
        r_active  <= '0;
        r_flagged <= '0;
        r_mode    <= mode_sel;
      end else if (w_running) begin
        if (w_move) begin
          r_min[r_active] <= w_inc_min;
          r_sec[r_active] <= w_inc_sec;
          r_presc         <= '0;
          r_active        <= (r_active == LAST_PLAYER) ? '0 : r_active + PW'(1);
        end else begin
          r_min[r_active] <= w_dec_min;
          r_sec[r_active] <= w_dec_sec;
          r_presc         <= w_tick ? '0 : r_presc + CW'(1);
          if (w_flag) r_flagged <= r_active;
        end
      end
    end
  end

  assign state          = r_state;
  assign active_player  = r_active;
  assign disp_bcd       = r_disp;
  assign time_up        = (r_state == S_FLAGGED);
  assign flagged_player = r_flagged;
  assign low_time       = w_running && (w_cur_min == 7'd0) && (w_cur_sec < 6'd10);

endmodule

// File: tb/tb_chess_clock.sv
// Bench for chess_clock: directed scenarios plus randomized traffic against a total-seconds reference model.
module tb_chess_clock;
  localparam int FREQ = 4;
  localparam int NP   = 2;
  localparam int PW   = 1;

  logic          clk = 1'b0;
  logic          reset, load, start, pause, moved;
  logic [1:0]    mode_sel;
  logic [PW-1:0] active_player, flagged_player;
  logic [15:0]   disp_bcd;
  logic [2:0]    state;
  logic          time_up, low_time;

  chess_clock #(.CLK_FREQ_HZ(FREQ), .NUM_PLAYERS(NP)) dut (
    .clk(clk), .reset(reset), .load(load), .mode_sel(mode_sel), .start(start),
    .pause(pause), .moved(moved), .active_player(active_player), .disp_bcd(disp_bcd),
    .state(state), .time_up(time_up), .flagged_player(flagged_player), .low_time(low_time)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: each player's time is a plain count of seconds.
  int          m_time [NP];
  int          m_state, m_active, m_flagged, m_presc, m_mode;
  logic [15:0] m_disp;
  int          BASE_MIN [4] = '{1, 3, 5, 10};
  int          INC_SEC  [4] = '{0, 2, 0, 5};

  function automatic logic [15:0] bcd_of(input int t);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    foreach (m_time[i]) m_time[i] = 0;
    m_state = 0; m_active = 0; m_flagged = 0; m_presc = 0; m_mode = 0; m_disp = 16'h0000;
  endtask

  task automatic model_edge(input bit ld, input bit [1:0] md, input bit st, input bit ps, input bit mv);
    int t;
    bit tick;
    m_disp = (m_state == 0) ? 16'h0000 : bcd_of(m_time[m_active]);
    if (ld) begin
      foreach (m_time[i]) m_time[i] = BASE_MIN[md] * 60;
      m_active = 0; m_presc = 0; m_flagged = 0; m_mode = md; m_state = 1;
    end else if (m_state == 1 || m_state == 3) begin
      if (st) m_state = 2;
    end else if (m_state == 2) begin
      tick = (m_presc == FREQ - 1);
      t = m_time[m_active] - (tick ? 1 : 0);
      if (tick && t == 0) begin
        m_time[m_active] = 0; m_presc = 0; m_flagged = m_active; m_state = 4;
      end else begin
        if (mv) begin
          t = t + INC_SEC[m_mode];
          if (t > 5999) t = 5999;
          m_time[m_active] = t;
          m_active = (m_active + 1) % NP;
          m_presc = 0;
        end else begin
          m_time[m_active] = t;
          m_presc = tick ? 0 : m_presc + 1;
        end
        if (ps) m_state = 3;
      end
    end
  endtask

  task automatic drive(input bit ld, input bit [1:0] md, input bit st, input bit ps, input bit mv);
    load = ld; mode_sel = md; start = st; pause = ps; moved = mv;
    @(posedge clk);
    model_edge(ld, md, st, ps, mv);
    @(negedge clk);
    load = 1'b0; start = 1'b0; pause = 1'b0; moved = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, mode_sel, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; moved = 1'b0; mode_sel = 2'd0;
    model_reset();
    @(negedge clk);
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (disp_bcd !== 16'h0000) begin n_bad++; $display("FAIL reset_disp: got %h want 0000", disp_bcd); end
    n_cmp++; if (time_up !== 1'b0 || low_time !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got up=%b low=%b want 0 0", time_up, low_time); end
    n_cmp++; if (active_player !== '0 || flagged_player !== '0) begin n_bad++; $display("FAIL reset_players: got act=%0d flag=%0d want 0 0", active_player, flagged_player); end
    reset = 1'b0;
    drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL idle_start_ignored: got %0d want 0", state); end
  endtask

  task automatic test_load();
    drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL load_state: got %0d want 1", state); end
    idle(1);
    n_cmp++; if (disp_bcd !== 16'h0300) begin n_bad++; $display("FAIL load_disp: got %h want 0300", disp_bcd); end
    n_cmp++; if (active_player !== '0) begin n_bad++; $display("FAIL load_active: got %0d want 0", active_player); end
  endtask

  task automatic test_run();
    drive(1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL run_state: got %0d want 2", state); end
    idle(9);
    n_cmp++; if (disp_bcd !== 16'h0258) begin n_bad++; $display("FAIL run_disp: got %h want 0258", disp_bcd); end
    n_cmp++; if (low_time !== 1'b0) begin n_bad++; $display("FAIL run_low: got %b want 0", low_time); end
  endtask

  task automatic test_increment();
    drive(1'b0, 2'd1, 1'b0, 1'b0, 1'b1);
    idle(1);
    n_cmp++; if (active_player !== 1'b1) begin n_bad++; $display("FAIL inc_active: got %0d want 1", active_player); end
    n_cmp++; if (disp_bcd !== 16'h0300) begin n_bad++; $display("FAIL inc_disp_p1: got %h want 0300", disp_bcd); end
    drive(1'b0, 2'd1, 1'b0, 1'b0, 1'b1);
    idle(1);
    n_cmp++; if (active_player !== 1'b0) begin n_bad++; $display("FAIL inc_wrap: got %0d want 0", active_player); end
    n_cmp++; if (disp_bcd !== 16'h0300) begin n_bad++; $display("FAIL inc_p0_stored: got %h want 0300", disp_bcd); end
  endtask

  task automatic test_pause();
    drive(1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
    idle(6);
    n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL pause_state: got %0d want 3", state); end
    n_cmp++; if (disp_bcd !== 16'h0300) begin n_bad++; $display("FAIL pause_frozen: got %h want 0300", disp_bcd); end
    drive(1'b0, 2'd1, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL both_from_paused: got %0d want 2", state); end
    drive(1'b0, 2'd1, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL both_from_running: got %0d want 3", state); end
    drive(1'b0, 2'd1, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (active_player !== 1'b0) begin n_bad++; $display("FAIL moved_paused_ignored: got %0d want 0", active_player); end
  endtask

  task automatic test_flag();
    int guard;
    drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    guard = 0;
    while (m_time[0] != 1 && guard < 400) begin idle(1); guard++; end
    n_cmp++; if (low_time !== 1'b1) begin n_bad++; $display("FAIL flag_low_time: got %b want 1", low_time); end
    guard = 0;
    while (m_state != 4 && guard < 10) begin idle(1); guard++; end
    n_cmp++; if (state !== 3'd4 || time_up !== 1'b1) begin n_bad++; $display("FAIL flag_state: got st=%0d up=%b want 4 1", state, time_up); end
    n_cmp++; if (flagged_player !== 1'b0) begin n_bad++; $display("FAIL flag_player: got %0d want 0", flagged_player); end
    n_cmp++; if (low_time !== 1'b0) begin n_bad++; $display("FAIL flag_low_cleared: got %b want 0", low_time); end
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (state !== 3'd4 || active_player !== 1'b0) begin n_bad++; $display("FAIL flag_frozen: got st=%0d act=%0d want 4 0", state, active_player); end
    n_cmp++; if (disp_bcd !== 16'h0000) begin n_bad++; $display("FAIL flag_disp: got %h want 0000", disp_bcd); end
  endtask

  task automatic test_collision();
    int guard;
    drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'd3, 1'b1, 1'b0, 1'b0);
    guard = 0;
    while (!(m_time[0] == 5 && m_presc == FREQ - 1) && guard < 3000) begin idle(1); guard++; end
    n_cmp++; if (guard >= 3000) begin n_bad++; $display("FAIL coll_reach: got timeout want 00:05"); end
    drive(1'b0, 2'd3, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 2'd3, 1'b0, 1'b0, 1'b1);
    idle(1);
    n_cmp++; if (disp_bcd !== 16'h0009) begin n_bad++; $display("FAIL coll_sum: got %h want 0009", disp_bcd); end
    n_cmp++; if (low_time !== 1'b1) begin n_bad++; $display("FAIL coll_low: got %b want 1", low_time); end
    guard = 0;
    while (!(m_time[0] == 1 && m_presc == FREQ - 1) && guard < 100) begin idle(1); guard++; end
    drive(1'b0, 2'd3, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (state !== 3'd4 || time_up !== 1'b1) begin n_bad++; $display("FAIL coll_flag: got st=%0d up=%b want 4 1", state, time_up); end
    n_cmp++; if (active_player !== 1'b0 || flagged_player !== 1'b0) begin n_bad++; $display("FAIL coll_player: got act=%0d flag=%0d want 0 0", active_player, flagged_player); end
  endtask

  task automatic test_saturation_reset();
    int guard;
    drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'd3, 1'b1, 1'b0, 1'b0);
    idle(8);
    guard = 0;
    while (!(m_active == 0 && m_time[0] == 5998) && guard < 4000) begin drive(1'b0, 2'd3, 1'b0, 1'b0, 1'b1); guard++; end
    idle(1);
    n_cmp++; if (disp_bcd !== 16'h9958) begin n_bad++; $display("FAIL sat_reach: got %h want 9958", disp_bcd); end
    drive(1'b0, 2'd3, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 2'd3, 1'b0, 1'b0, 1'b1);
    idle(1);
    n_cmp++; if (disp_bcd !== 16'h9959) begin n_bad++; $display("FAIL sat_clamp: got %h want 9959", disp_bcd); end
    idle(2);
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (state !== 3'd0 || disp_bcd !== 16'h0000) begin n_bad++; $display("FAIL async_reset: got st=%0d disp=%h want 0 0000", state, disp_bcd); end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    bit [1:0] md;
    bit ld, st, ps, mv;
    md = 2'($urandom_range(0, 3));
    drive(1'b1, md, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      ld = ($urandom_range(0, 199) == 0);
      if (ld) md = 2'($urandom_range(0, 3));
      st = ($urandom_range(0, 5) == 0);
      ps = ($urandom_range(0, 19) == 0);
      mv = ($urandom_range(0, 11) == 0);
      drive(ld, md, st, ps, mv);
      n_cmp++; if (state !== 3'(m_state)) begin n_bad++; $display("FAIL rnd_state @%0d: got %0d want %0d", i, state, m_state); end
      n_cmp++; if (active_player !== PW'(m_active)) begin n_bad++; $display("FAIL rnd_active @%0d: got %0d want %0d", i, active_player, m_active); end
      n_cmp++; if (disp_bcd !== m_disp) begin n_bad++; $display("FAIL rnd_disp @%0d: got %h want %h", i, disp_bcd, m_disp); end
      n_cmp++; if (time_up !== (m_state == 4)) begin n_bad++; $display("FAIL rnd_time_up @%0d: got %b want %b", i, time_up, m_state == 4); end
      n_cmp++; if (low_time !== (m_state == 2 && m_time[m_active] < 10)) begin n_bad++; $display("FAIL rnd_low @%0d: got %b", i, low_time); end
      if (m_state == 4) begin
        n_cmp++; if (flagged_player !== PW'(m_flagged)) begin n_bad++; $display("FAIL rnd_flagged @%0d: got %0d want %0d", i, flagged_player, m_flagged); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_run();
    test_increment();
    test_pause();
    test_flag();
    test_collision();
    test_saturation_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
